rs_encoder_serial: RTL and testbench
====================================

// Module: rs_encoder_serial
// PURPOSE
//  Systematic RS(255,239) encoder over GF(2^8), byte-serial; transmit-side counterpart of syndrome_slice.
//  Passes K message bytes through unchanged, then appends 16 parity bytes.
//  The stream checks to zero in all 16 syndromes (roots alpha^1..alpha^16) when byte p is weighted alpha^(p*(i+1)).
//  Sits between the payload source and the 128-bit beat packer feeding the channel.
// PARAMETERS
//  K     239  message bytes per frame, 1..239 (K<239 = shortened code; parity count is fixed at 16)
// PORTS
//  clk        in   1  clock, all state on rising edge
//  rst_n      in   1  asynchronous active-low reset
//  in_data    in   8  message byte
//  in_valid   in   1  in_data valid
//  in_last    in   1  source marks final message byte (checked only)
//  in_ready   out  1  encoder accepts a byte this cycle
//  out_data   out  8  codeword byte (registered)
//  out_valid  out  1  out_data valid (registered)
//  out_first  out  1  out_data is codeword byte 0
//  out_last   out  1  out_data is final parity byte
//  out_ready  in   1  sink accepts out_data
//  frame_err  out  1  one-cycle pulse: in_last disagrees with byte count
// BEHAVIOUR
//  Reset: out_data=0, out_valid=0, out_first=0, out_last=0, frame_err=0, lfsr=0, cnt=0, state=MSG.
//  Output slot free = !out_valid || out_ready; in_ready = (state==MSG) && slot free (comb).
//  Input accept = in_valid && in_ready; out_valid drops when slot free and nothing is loaded.
//  LFSR: 16 bytes r[15:0]. fb = in_data ^ r[15];
//    r[k] <= r[k-1] ^ gf_mul(fb,G[k]) for k>0; r[0] <= gf_mul(fb,G[0]).
//  G = monic g~(x) = prod_{i=1..16}(x + alpha^(255-i)), poly 0x11D, leading 1 implicit.
//  The byte stream is the descending-degree coefficient list of g~-multiple c~(x); valid for any K.
//  MSG state: on accept -> out_data<=in_data, out_valid<=1, out_first<=(cnt==0),
//    LFSR update, cnt++. Accepting byte cnt==K-1 -> state PAR, cnt<=0.
//  frame_err: pulses the cycle after accept if in_last != (cnt==K-1). Frame continues by count.
//  PAR state: in_ready=0. When slot free -> out_data<=r[15], out_valid<=1,
//    r <= {r[14:0],8'h00}, cnt++. Parity byte 15 also sets out_last=1; then state MSG, cnt<=0.
//  Latency: 1 cycle in accept -> out_valid. Throughput: 1 byte/cycle out; input stalls exactly 16 cycles/frame.
//  Backpressure: while out_valid && !out_ready, out_data, out_first and out_last are held and no state advances.
//  Back-to-back frames: the first message byte of the next frame can be accepted in the cycle after final parity is loaded.
//  Reset mid-frame discards the partial frame; the next accepted byte is byte 0.
//  Widths: cnt is 8 bits; GF add = XOR; gf_mul is pure combinational.
// STRUCTURE
//  rs_pkg: GF_POLY=9'h11D, RS_NPAR=16, RS_GEN[0:15] constant bytes of g~, state enum {MSG,PAR}.
//  Sub-modules: 16x gf256_mul (existing), constant operand G[k].
//  All logic in one module; no memory.
// TESTING
//  All-zero message, K=239 -> 255 zero bytes, out_first on byte 0, out_last on byte 254.
//  Random messages, out_ready=1 -> out bytes 0..238 == input; 16 syndromes over 255 bytes == 0.
//  Single 0x01 at byte 0, rest zero -> parity == C model; flip one out byte -> nonzero syndrome.
//  out_ready low 5 cycles at parity byte 3 -> byte held stable, 16 distinct parity bytes, none lost.
//  in_last at byte 100 -> frame_err pulse one cycle; frame still 255 bytes.
//  rst_n low at byte 50, then a full frame -> correct codeword. K=100 param -> 116 bytes, syndromes 0.

Source files
------------

// File: rtl/rs_pkg.sv
// rs_pkg: shared constants for the byte-serial RS(255,239) encoder.
//   GF_POLY  : field polynomial for GF(2^8), x^8+x^4+x^3+x^2+1
//   RS_NPAR  : parity bytes per codeword
//   RS_GEN   : low 16 coefficients of monic g~(x) = prod_{i=1..16}(x + alpha^-i),
//              RS_GEN[k] multiplies x^k; the x^16 term is an implicit 1
//   gf_mul   : pure combinational GF(2^8) multiply
package rs_pkg;
  localparam logic [8:0] GF_POLY      = 9'h11D;
  localparam int         RS_NPAR      = 16;
  // alpha^-1 under 0x11D: 0x8E * 2 = 0x11C, reduced -> 0x01
  localparam logic [7:0] GF_ALPHA_INV = 8'h8E;

  typedef enum logic {MSG = 1'b0, PAR = 1'b1} rs_state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY[7:0] : 8'h00);
    end
    return acc;
  endfunction

  // Expands the generator at elaboration: multiply by (x + root) for
  // root = alpha^-1 .. alpha^-16, coefficients kept in ascending degree.
  function automatic logic [RS_NPAR-1:0][7:0] rs_gen_calc();
    logic [RS_NPAR:0][7:0] g;
    logic [7:0]            root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 1; i <= RS_NPAR; i++) begin
      root = gf_mul(root, GF_ALPHA_INV);
      for (int k = i; k >= 1; k--) g[k] = g[k-1] ^ gf_mul(g[k], root);
      g[0] = gf_mul(g[0], root);
    end
    return g[RS_NPAR-1:0];
  endfunction

  localparam logic [RS_NPAR-1:0][7:0] RS_GEN = rs_gen_calc();
endpackage

// File: rtl/gf256_mul.sv
// gf256_mul: combinational GF(2^8) multiplier (poly 0x11D).
//   a, b : operands
//   p    : product
module gf256_mul
  import rs_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);
  assign p = gf_mul(a, b);
endmodule

// File: rtl/rs_encoder_serial.sv
// rs_encoder_serial: systematic RS(255,239) encoder, one byte per cycle.
// Message bytes pass straight through, then the 16 parity bytes held in the
// division LFSR are shifted out MSB-first. K < 239 gives a shortened code.
//   clk, rst_n          : clock, async active-low reset
//   in_data/valid/last  : message byte stream (in_last is only checked)
//   in_ready            : byte accepted this cycle when in_valid
//   out_data/valid      : registered codeword byte stream
//   out_first/out_last  : codeword byte 0 / final parity byte
//   out_ready           : sink accepts out_data
//   frame_err           : one-cycle pulse when in_last disagrees with the count
module rs_encoder_serial
  import rs_pkg::*;
#(
  parameter int K = 239
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_first,
  output logic       out_last,
  input  logic       out_ready,
  output logic       frame_err
);
  localparam logic [7:0] LAST_MSG = 8'(K - 1);
  localparam logic [7:0] LAST_PAR = 8'(RS_NPAR - 1);

  rs_state_e                   state, state_nxt;
  logic [7:0]                  cnt;
  logic [RS_NPAR-1:0][7:0]     r;
  logic [RS_NPAR-1:0][7:0]     prod;
  logic [RS_NPAR-1:0][7:0]     r_div;
  logic [7:0]                  fb;
  logic                        slot_free;
  logic                        accept;
  logic                        par_load;
  logic                        cnt_last_msg;
  logic                        cnt_last_par;

  assign fb           = in_data ^ r[RS_NPAR-1];
  assign slot_free    = !out_valid || out_ready;
  assign accept       = in_valid && in_ready;
  assign par_load     = (state == PAR) && slot_free;
  assign cnt_last_msg = (cnt == LAST_MSG);
  assign cnt_last_par = (cnt == LAST_PAR);

  // Feedback times each generator coefficient.
  for (genvar k = 0; k < RS_NPAR; k++) begin : g_mul
    gf256_mul u_mul (
      .a (fb),
      .b (RS_GEN[k]),
      .p (prod[k])
    );
  end

  always_comb begin
    r_div[0] = prod[0];
    for (int k = 1; k < RS_NPAR; k++) r_div[k] = r[k-1] ^ prod[k];
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MSG;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      MSG: if (accept && cnt_last_msg)   state_nxt = PAR;
      PAR: if (par_load && cnt_last_par) state_nxt = MSG;
      default:                           state_nxt = MSG;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state == MSG) && slot_free;
  end

  // Datapath. Under backpressure neither branch fires, so every register
  // (outputs, LFSR, count) holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      frame_err <= 1'b0;
      r         <= '0;
      cnt       <= '0;
    end else begin
      frame_err <= 1'b0;
      if (accept) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
        out_first <= (cnt == 8'd0);
        out_last  <= 1'b0;
        r         <= r_div;
        cnt       <= cnt_last_msg ? 8'd0 : cnt + 8'd1;
        // Framing follows the count; in_last is advisory only.
        frame_err <= (in_last != cnt_last_msg);
      end else if (par_load) begin
        out_data  <= r[RS_NPAR-1];
        out_valid <= 1'b1;
        out_first <= 1'b0;
        out_last  <= cnt_last_par;
        r         <= {r[RS_NPAR-2:0], 8'h00};
        cnt       <= cnt_last_par ? 8'd0 : cnt + 8'd1;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rs_encoder_serial.sv
module tb_rs_encoder_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a_in_data, a_out_data, b_in_data, b_out_data;
  logic a_in_valid, a_in_last, a_in_ready, a_out_valid, a_out_first, a_out_last, a_out_ready, a_frame_err;
  logic b_in_valid, b_in_last, b_in_ready, b_out_valid, b_out_first, b_out_last, b_out_ready, b_frame_err;

  rs_encoder_serial #(.K(239)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid), .out_first(a_out_first),
    .out_last(a_out_last), .out_ready(a_out_ready), .frame_err(a_frame_err));

  rs_encoder_serial #(.K(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid), .out_first(b_out_first),
    .out_last(b_out_last), .out_ready(b_out_ready), .frame_err(b_frame_err));

  int sel = 0;
  logic [7:0] c_out_data;
  logic c_in_ready, c_out_valid, c_out_first, c_out_last, c_frame_err;
  assign c_in_ready  = (sel != 0) ? b_in_ready  : a_in_ready;
  assign c_out_data  = (sel != 0) ? b_out_data  : a_out_data;
  assign c_out_valid = (sel != 0) ? b_out_valid : a_out_valid;
  assign c_out_first = (sel != 0) ? b_out_first : a_out_first;
  assign c_out_last  = (sel != 0) ? b_out_last  : a_out_last;
  assign c_frame_err = (sel != 0) ? b_frame_err : a_frame_err;

  logic [7:0] msg [0:1023];
  logic [7:0] cap [0:1023];
  bit         capf [0:1023];
  bit         capl [0:1023];
  logic [7:0] gen [0:16];
  logic [7:0] exp_par [0:15];
  logic [7:0] w [0:511];

  int oc, ai, cyc, stalls, hold_bad, fe_cnt, fe_idx, first_cyc, last_cyc, gaps;
  int n_cmp = 0;
  int n_bad = 0;

  // GF(2^8) multiply, MSB-first Horner on b
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1D : 8'h00);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  // Number of nonzero syndromes S_i = sum_p cap[base+p] * alpha^(p*i), i=1..16
  function automatic int synd_nz(input int base, input int n);
    logic [7:0] a, s;
    int nz;
    nz = 0;
    a = 8'h01;
    for (int i = 1; i <= 16; i++) begin
      a = gm(a, 8'h02);
      s = 8'h00;
      for (int p = n - 1; p >= 0; p--) s = gm(s, a) ^ cap[base + p];
      if (s != 8'h00) nz++;
    end
    return nz;
  endfunction

  // Generator by explicit root product, roots alpha^(255-i)
  task automatic build_gen();
    logic [7:0] root;
    for (int j = 0; j <= 16; j++) gen[j] = 8'h00;
    gen[0] = 8'h01;
    for (int i = 1; i <= 16; i++) begin
      root = 8'h01;
      for (int e = 0; e < 255 - i; e++) root = gm(root, 8'h02);
      for (int j = i; j >= 1; j--) gen[j] = gen[j-1] ^ gm(gen[j], root);
      gen[0] = gm(gen[0], root);
    end
  endtask

  // Parity by long division of msg[base..base+k-1] * x^16 by g
  task automatic model_par(input int base, input int k);
    for (int p = 0; p < k + 16; p++) w[p] = (p < k) ? msg[base + p] : 8'h00;
    for (int p = 0; p < k; p++) begin
      logic [7:0] f;
      f = w[p];
      for (int j = 0; j <= 16; j++) w[p + j] = w[p + j] ^ gm(f, gen[16 - j]);
    end
    for (int t = 0; t < 16; t++) exp_par[t] = w[k + t];
  endtask

  task automatic set_in(input logic v, input logic [7:0] d, input logic l, input logic rdy);
    if (sel == 0) begin a_in_valid = v; a_in_data = d; a_in_last = l; a_out_ready = rdy; end
    else          begin b_in_valid = v; b_in_data = d; b_in_last = l; b_out_ready = rdy; end
  endtask

  task automatic do_reset();
    a_in_valid = 0; a_in_data = 0; a_in_last = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = 0; b_in_last = 0; b_out_ready = 1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Streams nf frames of k bytes from msg[], captures the output into cap[].
  task automatic drive(input int k, input int nf, input int last_extra, input int stall_at, input int abort_at);
    int total_in, total_out, stall_left;
    bit stall_started, held_v, vld, rdy, lst;
    logic [7:0] held_d;
    total_in = k * nf; total_out = (k + 16) * nf;
    oc = 0; ai = 0; cyc = 0; stalls = 0; hold_bad = 0; fe_cnt = 0; fe_idx = -1;
    first_cyc = -1; last_cyc = -1; stall_left = 0; stall_started = 0; held_v = 0; held_d = 0;
    while (oc < total_out && cyc < 3000 && !(abort_at >= 0 && ai >= abort_at)) begin
      @(negedge clk);
      rdy = 1;
      if (stall_at >= 0 && oc == stall_at && !stall_started) begin stall_started = 1; stall_left = 5; end
      if (stall_left > 0) begin rdy = 0; stall_left--; end
      vld = (ai < total_in);
      lst = ((ai % k) == k - 1) || (ai == last_extra);
      set_in(vld, vld ? msg[ai] : 8'h00, lst, rdy);
      #1;
      if (c_frame_err) begin fe_cnt++; fe_idx = ai - 1; end
      if (held_v && c_out_data !== held_d) hold_bad++;
      held_v = !rdy && c_out_valid;
      held_d = c_out_data;
      if (vld && !c_in_ready) stalls++;
      if (vld && c_in_ready) ai++;
      if (c_out_valid && rdy) begin
        cap[oc] = c_out_data; capf[oc] = c_out_first; capl[oc] = c_out_last;
        oc++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      cyc++;
    end
    @(posedge clk); #1;
    set_in(1'b0, 8'h00, 1'b0, 1'b1);
    gaps = last_cyc - first_cyc + 1 - oc;
  endtask

  task automatic test_reset();
    sel = 0;
    a_in_valid = 0; a_in_data = 0; a_in_last = 0; a_out_ready = 1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    n_cmp++; if (a_out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got %h want 00", a_out_data); end
    n_cmp++; if (a_out_first !== 1'b0) begin n_bad++; $display("FAIL reset_out_first got %b want 0", a_out_first); end
    n_cmp++; if (a_out_last !== 1'b0) begin n_bad++; $display("FAIL reset_out_last got %b want 0", a_out_last); end
    n_cmp++; if (a_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got %b want 0", a_frame_err); end
    n_cmp++; if (a_in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", a_in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    a_in_valid = 1; a_in_data = 8'hA5;
    @(negedge clk);
    a_in_valid = 0;
    #1;
    n_cmp++; if (a_out_valid !== 1'b1 || a_out_data !== 8'hA5 || a_out_first !== 1'b1)
      begin n_bad++; $display("FAIL latency got v=%b d=%h f=%b want v=1 d=a5 f=1", a_out_valid, a_out_data, a_out_first); end
    @(negedge clk); #1;
    n_cmp++; if (a_out_valid !== 1'b0) begin n_bad++; $display("FAIL valid_drop got %b want 0", a_out_valid); end
  endtask

  task automatic test_zero();
    int errs, nf, nl;
    sel = 0; do_reset();
    for (int i = 0; i < 239; i++) msg[i] = 8'h00;
    drive(239, 1, -1, -1, -1);
    errs = 0; nf = 0; nl = 0;
    for (int i = 0; i < oc; i++) begin
      if (cap[i] != 8'h00) errs++;
      if (capf[i]) nf++;
      if (capl[i]) nl++;
    end
    n_cmp++; if (oc !== 255) begin n_bad++; $display("FAIL zero_count got %0d want 255", oc); end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL zero_bytes got %0d nonzero want 0", errs); end
    n_cmp++; if (nf !== 1 || capf[0] !== 1'b1) begin n_bad++; $display("FAIL zero_first got %0d flags, byte0=%b want 1,1", nf, capf[0]); end
    n_cmp++; if (nl !== 1 || capl[254] !== 1'b1) begin n_bad++; $display("FAIL zero_last got %0d flags, byte254=%b want 1,1", nl, capl[254]); end
  endtask

  task automatic test_random();
    int errs;
    sel = 0; do_reset();
    for (int i = 0; i < 239; i++) msg[i] = 8'($urandom);
    drive(239, 1, -1, -1, -1);
    errs = 0;
    for (int i = 0; i < 239; i++) if (cap[i] !== msg[i]) errs++;
    n_cmp++; if (oc !== 255) begin n_bad++; $display("FAIL rand_count got %0d want 255", oc); end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL rand_passthru got %0d diffs want 0", errs); end
    n_cmp++; if (synd_nz(0, 255) !== 0) begin n_bad++; $display("FAIL rand_synd got %0d nonzero want 0", synd_nz(0, 255)); end
    n_cmp++; if (fe_cnt !== 0) begin n_bad++; $display("FAIL rand_frame_err got %0d want 0", fe_cnt); end
  endtask

  task automatic test_single();
    int nz;
    logic [7:0] keep;
    sel = 0; do_reset();
    for (int i = 0; i < 239; i++) msg[i] = 8'h00;
    msg[0] = 8'h01;
    drive(239, 1, -1, -1, -1);
    model_par(0, 239);
    for (int t = 0; t < 16; t++) begin
      n_cmp++; if (cap[239 + t] !== exp_par[t]) begin n_bad++; $display("FAIL single_par%0d got %h want %h", t, cap[239 + t], exp_par[t]); end
    end
    n_cmp++; if (synd_nz(0, 255) !== 0) begin n_bad++; $display("FAIL single_synd got %0d want 0", synd_nz(0, 255)); end
    keep = cap[7];
    cap[7] = cap[7] ^ 8'h5A;
    nz = synd_nz(0, 255);
    cap[7] = keep;
    n_cmp++; if (nz === 0) begin n_bad++; $display("FAIL single_flip got %0d nonzero want >0", nz); end
  endtask

  task automatic test_backpressure();
    int errs;
    sel = 0; do_reset();
    for (int i = 0; i < 239; i++) msg[i] = 8'($urandom);
    drive(239, 1, -1, 242, -1);
    model_par(0, 239);
    errs = 0;
    for (int t = 0; t < 16; t++) if (cap[239 + t] !== exp_par[t]) errs++;
    n_cmp++; if (oc !== 255) begin n_bad++; $display("FAIL bp_count got %0d want 255", oc); end
    n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL bp_hold got %0d changes want 0", hold_bad); end
    n_cmp++; if (gaps !== 5) begin n_bad++; $display("FAIL bp_gaps got %0d want 5", gaps); end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL bp_parity got %0d diffs want 0", errs); end
    n_cmp++; if (capl[254] !== 1'b1) begin n_bad++; $display("FAIL bp_last got %b want 1", capl[254]); end
  endtask

  task automatic test_frame_err();
    sel = 0; do_reset();
    for (int i = 0; i < 239; i++) msg[i] = 8'($urandom);
    drive(239, 1, 100, -1, -1);
    n_cmp++; if (fe_cnt !== 1) begin n_bad++; $display("FAIL ferr_pulses got %0d want 1", fe_cnt); end
    n_cmp++; if (fe_idx !== 100) begin n_bad++; $display("FAIL ferr_index got %0d want 100", fe_idx); end
    n_cmp++; if (oc !== 255) begin n_bad++; $display("FAIL ferr_count got %0d want 255", oc); end
    n_cmp++; if (synd_nz(0, 255) !== 0) begin n_bad++; $display("FAIL ferr_synd got %0d want 0", synd_nz(0, 255)); end
  endtask

  task automatic test_reset_mid();
    int errs;
    sel = 0; do_reset();
    for (int i = 0; i < 239; i++) msg[i] = 8'($urandom);
    drive(239, 1, -1, -1, 50);
    do_reset();
    for (int i = 0; i < 239; i++) msg[i] = 8'($urandom);
    drive(239, 1, -1, -1, -1);
    errs = 0;
    for (int i = 0; i < 239; i++) if (cap[i] !== msg[i]) errs++;
    n_cmp++; if (oc !== 255) begin n_bad++; $display("FAIL rmid_count got %0d want 255", oc); end
    n_cmp++; if (capf[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_first got %b want 1", capf[0]); end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL rmid_passthru got %0d diffs want 0", errs); end
    n_cmp++; if (synd_nz(0, 255) !== 0) begin n_bad++; $display("FAIL rmid_synd got %0d want 0", synd_nz(0, 255)); end
  endtask

  task automatic test_back_to_back();
    sel = 0; do_reset();
    for (int i = 0; i < 478; i++) msg[i] = 8'($urandom);
    drive(239, 2, -1, -1, -1);
    n_cmp++; if (oc !== 510) begin n_bad++; $display("FAIL b2b_count got %0d want 510", oc); end
    n_cmp++; if (stalls !== 16) begin n_bad++; $display("FAIL b2b_stalls got %0d want 16", stalls); end
    n_cmp++; if (gaps !== 0) begin n_bad++; $display("FAIL b2b_gaps got %0d want 0", gaps); end
    n_cmp++; if (capf[255] !== 1'b1 || capl[509] !== 1'b1) begin n_bad++; $display("FAIL b2b_flags got f=%b l=%b want 1,1", capf[255], capl[509]); end
    n_cmp++; if (cap[255] !== msg[239]) begin n_bad++; $display("FAIL b2b_byte0 got %h want %h", cap[255], msg[239]); end
    n_cmp++; if (synd_nz(0, 255) !== 0) begin n_bad++; $display("FAIL b2b_synd0 got %0d want 0", synd_nz(0, 255)); end
    n_cmp++; if (synd_nz(255, 255) !== 0) begin n_bad++; $display("FAIL b2b_synd1 got %0d want 0", synd_nz(255, 255)); end
  endtask

  task automatic test_short();
    int errs;
    sel = 1; do_reset();
    for (int i = 0; i < 100; i++) msg[i] = 8'($urandom);
    drive(100, 1, -1, -1, -1);
    model_par(0, 100);
    errs = 0;
    for (int i = 0; i < 100; i++) if (cap[i] !== msg[i]) errs++;
    for (int t = 0; t < 16; t++) if (cap[100 + t] !== exp_par[t]) errs++;
    n_cmp++; if (oc !== 116) begin n_bad++; $display("FAIL short_count got %0d want 116", oc); end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL short_bytes got %0d diffs want 0", errs); end
    n_cmp++; if (capl[115] !== 1'b1 || capf[0] !== 1'b1) begin n_bad++; $display("FAIL short_flags got f=%b l=%b want 1,1", capf[0], capl[115]); end
    n_cmp++; if (synd_nz(0, 116) !== 0) begin n_bad++; $display("FAIL short_synd got %0d want 0", synd_nz(0, 116)); end
    sel = 0;
  endtask

  initial begin
    build_gen();
    test_reset();
    test_zero();
    test_random();
    test_single();
    test_backpressure();
    test_frame_err();
    test_reset_mid();
    test_back_to_back();
    test_short();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
